// File: rtl/wash_cycle_sequencer.sv
// Washing-machine phase sequencer: LOCK -> WASH -> RINSE -> SPIN -> DONE with a
// prescaled per-phase unit timer, pause hold, abort and door-open fault handling.
module wash_cycle_sequencer #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cycle_ready,
  input  logic [3:0] wash_duration,
  input  logic [3:0] rinse_duration,
  input  logic [3:0] spin_duration,
  input  logic       door_closed,
  input  logic       pause,
  input  logic       abort,
  output logic [2:0] phase,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       door_lock,
  output logic       water_valve,
  output logic       motor_on,
  output logic       drain_pump,
  output logic       done,
  output logic       fault
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PreLast = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLock  = 3'd1,
    StWash  = 3'd2,
    StRinse = 3'd3,
    StSpin  = 3'd4,
    StDone  = 3'd5,
    StFault = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    rem_q, rem_d;
  logic [3:0]    wash_q, wash_d;
  logic [3:0]    rinse_q, rinse_d;
  logic [3:0]    spin_q, spin_d;
  // Set when the last edge held a running phase because of pause.
  logic          paused_q, paused_d;
  logic          advance;

  // State, timer and latched-duration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      rem_q    <= '0;
      wash_q   <= '0;
      rinse_q  <= '0;
      spin_q   <= '0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      rem_q    <= rem_d;
      wash_q   <= wash_d;
      rinse_q  <= rinse_d;
      spin_q   <= spin_d;
      paused_q <= paused_d;
    end
  end

  // Next-state logic; priority abort > door fault > pause > timer.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    wash_d   = wash_q;
    rinse_d  = rinse_q;
    spin_d   = spin_q;
    paused_d = 1'b0;
    advance  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cycle_ready && door_closed) begin
          wash_d  = wash_duration;
          rinse_d = rinse_duration;
          spin_d  = spin_duration;
          state_d = StLock;
        end
      end
      StLock: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!door_closed) begin
          state_d = StFault;
        end else begin
          state_d = StWash;
          rem_d   = wash_q;
          presc_d = '0;
        end
      end
      StWash, StRinse, StSpin: begin
        if (abort) begin
          state_d = StIdle;
          rem_d   = '0;
          presc_d = '0;
        end else if (!door_closed) begin
          state_d = StFault;
          rem_d   = '0;
          presc_d = '0;
        end else if (pause) begin
          paused_d = 1'b1;
        end else if (rem_q == 4'd0) begin
          // Zero-length phase: one clock, then move on.
          advance = 1'b1;
        end else if (presc_q == PreLast) begin
          presc_d = '0;
          if (rem_q == 4'd1) begin
            advance = 1'b1;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StFault: begin
        if (abort) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        rem_d   = '0;
        presc_d = '0;
      end
    endcase

    if (advance) begin
      presc_d = '0;
      case (state_q)
        StWash: begin
          state_d = StRinse;
          rem_d   = rinse_q;
        end
        StRinse: begin
          state_d = StSpin;
          rem_d   = spin_q;
        end
        default: begin
          state_d = StDone;
          rem_d   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    phase       = state_q;
    remaining   = rem_q;
    busy        = (state_q != StIdle);
    door_lock   = (state_q == StLock) || (state_q == StWash) || (state_q == StRinse) ||
                  (state_q == StSpin) || (state_q == StDone);
    water_valve = ((state_q == StWash) || (state_q == StRinse)) && !paused_q;
    motor_on    = ((state_q == StWash) || (state_q == StRinse) || (state_q == StSpin)) &&
                  !paused_q;
    drain_pump  = (state_q == StSpin) && !paused_q;
    done        = (state_q == StDone);
    fault       = (state_q == StFault);
  end

endmodule
